dd_puf_scheduler: RTL

Sequencer that drives the delay-difference PUF controller through a programmable number of back-to-back evaluations of the same challenge. It captures the first 128-bit response as the reference and accumulates a per-bit instability mask over the later repetitions. It sits between the SPI register file (host side) and the DD PUF controller's CODE/CNT_VAL/DONE/PUF_OUT_REG interface.

---
 rtl/dd_puf_scheduler.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dd_puf_scheduler.sv
// dd_puf_scheduler: repeats one DD PUF challenge REPS times, keeps the first response
// and accumulates a per-bit instability mask. Define DD_SCHED_TIMEOUT_EN for the DONE timeout.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | CODE_OUT=0, waiting for START
// S_ARM     | CODE_OUT=1, waiting for the controller DONE pulse
// S_RELEASE | CODE_OUT=0 for GAP_CYCLES cycles so the controller re-arms
// S_FINISH  | one-cycle VALID, popcount of the instability mask latched
module dd_puf_scheduler #(
  parameter int unsigned GAP_CYCLES = 4
`ifdef DD_SCHED_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_MARGIN = 16
`endif
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic [7:0]   REPS,
  input  logic [15:0]  CNT_VAL,
  output logic [7:0]   CODE_OUT,
  output logic [15:0]  CNT_VAL_OUT,
  input  logic         DONE_IN,
  input  logic [127:0] PUF_IN,
  output logic         BUSY,
  output logic         VALID,
  output logic [127:0] RESP,
  output logic [127:0] UNSTABLE,
  output logic [7:0]   UNSTABLE_CNT,
  output logic         ERR
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RELEASE, S_FINISH} state_t;

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  state_t         state_q, state_d;
  logic [7:0]     reps_q, reps_d;
  logic [7:0]     rep_idx_q, rep_idx_d;
  logic [7:0]     gap_q, gap_d;
  logic [15:0]    cnt_val_q, cnt_val_d;
  logic [127:0]   resp_q, resp_d;
  logic [127:0]   unstable_q, unstable_d;
  logic [7:0]     ucnt_q, ucnt_d;
  logic           busy_q, busy_d;
  logic [7:0]     code;
  logic           valid;
  logic [7:0]     popcnt;
`ifdef DD_SCHED_TIMEOUT_EN
  logic           err_q, err_d;
  logic [16:0]    tmo_q, tmo_d;
  logic [16:0]    tmo_limit;

  assign tmo_limit = {1'b0, cnt_val_q} + 17'(TIMEOUT_MARGIN);
`endif

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < 128; i++) begin
      popcnt = popcnt + 8'(unstable_q[i]);
    end
  end

  always_comb begin
    state_d    = state_q;
    reps_d     = reps_q;
    rep_idx_d  = rep_idx_q;
    gap_d      = gap_q;
    cnt_val_d  = cnt_val_q;
    resp_d     = resp_q;
    unstable_d = unstable_q;
    ucnt_d     = ucnt_q;
    busy_d     = busy_q;
    code       = 8'd0;
    valid      = 1'b0;
`ifdef DD_SCHED_TIMEOUT_EN
    err_d      = err_q;
    tmo_d      = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (START) begin
          reps_d     = (REPS == 8'd0) ? 8'd1 : REPS;
          cnt_val_d  = CNT_VAL;
          rep_idx_d  = 8'd0;
          unstable_d = '0;
          busy_d     = 1'b1;
          state_d    = S_ARM;
`ifdef DD_SCHED_TIMEOUT_EN
          err_d      = 1'b0;
          tmo_d      = '0;
`endif
        end
      end
      S_ARM: begin
        code = 8'd1;
        if (DONE_IN) begin
          if (rep_idx_q == 8'd0) begin
            resp_d     = PUF_IN;
            unstable_d = '0;
          end else begin
            unstable_d = unstable_q | (resp_q ^ PUF_IN);
          end
          rep_idx_d = rep_idx_q + 8'd1;
          gap_d     = GAP_LOAD;
          state_d   = S_RELEASE;
        end
`ifdef DD_SCHED_TIMEOUT_EN
        // DONE has priority over a timeout in the same cycle
        else if ((tmo_q + 17'd1) == tmo_limit) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          tmo_d = tmo_q + 17'd1;
        end
`endif
      end
      S_RELEASE: begin
        if (gap_q == 8'd0) begin
          state_d = (rep_idx_q == reps_q) ? S_FINISH : S_ARM;
`ifdef DD_SCHED_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      S_FINISH: begin
        ucnt_d  = popcnt;
        valid   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      reps_q     <= 8'd0;
      rep_idx_q  <= 8'd0;
      gap_q      <= 8'd0;
      cnt_val_q  <= 16'd0;
      resp_q     <= '0;
      unstable_q <= '0;
      ucnt_q     <= 8'd0;
      busy_q     <= 1'b0;
`ifdef DD_SCHED_TIMEOUT_EN
      err_q      <= 1'b0;
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      reps_q     <= reps_d;
      rep_idx_q  <= rep_idx_d;
      gap_q      <= gap_d;
      cnt_val_q  <= cnt_val_d;
      resp_q     <= resp_d;
      unstable_q <= unstable_d;
      ucnt_q     <= ucnt_d;
      busy_q     <= busy_d;
`ifdef DD_SCHED_TIMEOUT_EN
      err_q      <= err_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign CODE_OUT     = code;
  assign CNT_VAL_OUT  = cnt_val_q;
  assign BUSY         = busy_q;
  assign VALID        = valid;
  assign RESP         = resp_q;
  assign UNSTABLE     = unstable_q;
  assign UNSTABLE_CNT = ucnt_q;
`ifdef DD_SCHED_TIMEOUT_EN
  assign ERR          = err_q;
`else
  assign ERR          = 1'b0;
`endif

endmodule
